seg_capture: RTL
================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter NUM_SEG, default 6, number of multiplexed digits.
REQ-002 Parameter STABLE_CNT, default 4, consecutive identical samples required to commit a digit.
REQ-003 Parameter FIFO_DEPTH, default 4, event FIFO entries (power of two).
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 dig_sel  input  NUM_SEG  one-hot digit strobe of a scanned 7-seg bus, bit i selects digit i.
REQ-007 seg_in  input  8  segment lines; bit 7 = dp, bits 6:0 = g..a, same encoding as myPkg::seg_drv.
REQ-008 evt_ready  input  1  consumer accepts the event at the head of the FIFO.
REQ-009 ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 evt_valid  output  1  FIFO head holds an event.
REQ-011 evt_idx  output  $clog2(NUM_SEG)  digit index of the head event.
REQ-012 evt_nib, evt_dp, evt_err  output  4/1/1  decoded nibble, decimal point, undecodable-pattern flag.
REQ-013 nib_out  output  unpacked [0:NUM_SEG-1] of 4 bits  last committed nibble per digit.
REQ-014 digit_vld  output  NUM_SEG  digit i has committed at least once.
REQ-015 ovf  output  1  sticky, an event was dropped.

Function
REQ-016 The block SHALL register dig_sel and seg_in once; all decisions use the registered sample.
REQ-017 A sample SHALL be valid only when the registered dig_sel is exactly one-hot; a zero or multi-hot sample SHALL return the FSM to IDLE.
REQ-018 The FSM SHALL have states IDLE, TRACK, LOCKED.
REQ-019 IDLE -> TRACK on a valid sample, loading the run counter with 1.
REQ-020 TRACK: same dig_sel and seg_in as the previous sample increments the counter; a different valid sample reloads it with 1 and stays in TRACK.
REQ-021 TRACK -> LOCKED on the edge where the counter reaches STABLE_CNT; that edge is the commit.
REQ-022 LOCKED SHALL hold while the sample is unchanged; any change of dig_sel or seg_in SHALL go to TRACK (counter 1), or IDLE if the sample is invalid.
REQ-023 With inputs constant from edge E (first registering), commit SHALL occur at edge E+STABLE_CNT; nib_out and digit_vld update at that edge.
REQ-024 Decode SHALL use myPkg::seg_dec on bits 6:0; an unmatched pattern sets err=1 and leaves nib_out unchanged.
REQ-025 A commit SHALL write an event {idx, nib, dp, err} into the FIFO only if err=1, digit_vld[idx]=0, or nib/dp differ from the stored values.
REQ-026 evt_valid SHALL assert the edge after the write when the FIFO was empty (one-cycle latency).
REQ-027 A pop SHALL occur on evt_valid && evt_ready; outputs then present the next entry or deassert evt_valid.
REQ-028 Write into a full FIFO SHALL be dropped and set ovf, unless a pop occurs the same cycle, in which case the write is accepted.
REQ-029 ovf_clr SHALL clear ovf; a simultaneous overflow SHALL win (ovf stays 1).
REQ-030 Pointer arithmetic SHALL wrap modulo FIFO_DEPTH, with a separate count distinguishing full from empty.

Reset
REQ-031 rst_n low SHALL immediately force FSM IDLE, counter 0, FIFO empty, evt_valid 0, ovf 0, digit_vld 0, nib_out all 4'h0, and input registers 0; event payload outputs SHALL read 0.
REQ-032 Reset mid-TRACK or with the FIFO non-empty SHALL discard all progress; no event SHALL survive reset.

Structure
REQ-033 myPkg SHALL hold seg_dec (inverse of seg_drv, returns {ok, nib}), typedef seg_evt_t {idx, nib, dp, err}, and constant SEG_DP_BIT=7.
REQ-034 The FIFO SHALL be a sub-module evt_fifo parameterised on depth and seg_evt_t; FSM and decode stay in seg_capture.

Verification
REQ-035 dig_sel=6'b000100, seg_in=seg_drv(4'hA) for 4 cycles -> nib_out[2]=4'hA, digit_vld=6'b000100, one event {2,A,0,0}.
REQ-036 Same digit/pattern held 20 cycles, then re-held after a 1-cycle dig_sel=0 gap -> exactly one event total.
REQ-037 dig_sel=6'b000011 for 10 cycles -> no commit, no event, FSM stays IDLE.
REQ-038 seg_in=8'h7F-like undecodable code 8'h49 on digit 0 for 4 cycles -> event {0,0,0,1}, nib_out[0] unchanged.
REQ-039 evt_ready=0, six distinct commits -> 4 events held, ovf=1; ovf_clr with evt_ready=1 -> ovf 0, events drain in order.
REQ-040 rst_n low for one cycle while counter=3 and FIFO holds 2 -> all outputs at reset values, no event after release.

Source files
------------

// File: rtl/seg_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : myPkg (package)
//  Description : Shared definitions for the scanned 7-segment capture block:
//                segment encode/decode helpers, event record type and the
//                decimal-point bit position.
//                Segment byte layout: bit 7 = dp, bits 6:0 = g..a (active high)
//  Revision    : 1.0  initial release
// ============================================================================
package myPkg;

    localparam int SEG_DP_BIT = 7;
    localparam int SEG_IDX_W  = 3;

    typedef struct packed {
        logic [SEG_IDX_W-1:0] idx;
        logic [3:0]           nib;
        logic                 dp;
        logic                 err;
    } seg_evt_t;

    // Nibble to segment byte (dp cleared).
    function automatic logic [7:0] seg_drv(input logic [3:0] nib);
        logic [6:0] w_pat;
        case (nib)
            4'h0: w_pat = 7'h3F;
            4'h1: w_pat = 7'h06;
            4'h2: w_pat = 7'h5B;
            4'h3: w_pat = 7'h4F;
            4'h4: w_pat = 7'h66;
            4'h5: w_pat = 7'h6D;
            4'h6: w_pat = 7'h7D;
            4'h7: w_pat = 7'h07;
            4'h8: w_pat = 7'h7F;
            4'h9: w_pat = 7'h6F;
            4'hA: w_pat = 7'h77;
            4'hB: w_pat = 7'h7C;
            4'hC: w_pat = 7'h39;
            4'hD: w_pat = 7'h5E;
            4'hE: w_pat = 7'h79;
            default: w_pat = 7'h71;
        endcase
        return {1'b0, w_pat};
    endfunction

    // Inverse of seg_drv on bits 6:0. Returns {ok, nib}; unknown patterns
    // give ok=0 and nib=0.
    function automatic logic [4:0] seg_dec(input logic [6:0] pat);
        logic [4:0] w_res;
        case (pat)
            7'h3F: w_res = {1'b1, 4'h0};
            7'h06: w_res = {1'b1, 4'h1};
            7'h5B: w_res = {1'b1, 4'h2};
            7'h4F: w_res = {1'b1, 4'h3};
            7'h66: w_res = {1'b1, 4'h4};
            7'h6D: w_res = {1'b1, 4'h5};
            7'h7D: w_res = {1'b1, 4'h6};
            7'h07: w_res = {1'b1, 4'h7};
            7'h7F: w_res = {1'b1, 4'h8};
            7'h6F: w_res = {1'b1, 4'h9};
            7'h77: w_res = {1'b1, 4'hA};
            7'h7C: w_res = {1'b1, 4'hB};
            7'h39: w_res = {1'b1, 4'hC};
            7'h5E: w_res = {1'b1, 4'hD};
            7'h79: w_res = {1'b1, 4'hE};
            7'h71: w_res = {1'b1, 4'hF};
            default: w_res = 5'b0;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_capture_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : evt_fifo
//  Description : Small synchronous FIFO of seg_evt_t records. A write into a
//                full FIFO is accepted only when a pop happens in the same
//                cycle; otherwise it is ignored (the parent flags overflow).
//  Ports       : clk, rst_n          clock, async active-low reset
//                wr_en, wr_data      push request and record
//                rd_en               pop request (ignored when empty)
//                rd_data             head record, zero when empty
//                valid, full         occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module evt_fifo
    import myPkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_en,
    input  seg_evt_t wr_data,
    input  logic     rd_en,
    output seg_evt_t rd_data,
    output logic     valid,
    output logic     full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    seg_evt_t         r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign valid  = (r_count != '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign w_pop  = rd_en && valid;
    assign w_push = wr_en && (!full || w_pop);

    // Gate the head so a drained FIFO never exposes stale payload.
    assign rd_data = valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: reads are gated by the count.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg_capture
//  Description : Snoops a scanned 7-segment bus, debounces each digit until
//                its sample has been stable for STABLE_CNT registered samples,
//                decodes it and queues change events for a consumer.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                dig_sel, seg_in            scanned digit strobe and segments
//                evt_ready, ovf_clr         consumer handshake, overflow clear
//                evt_valid/idx/nib/dp/err   head event of the FIFO
//                nib_out, digit_vld         committed nibble / valid per digit
//                ovf                        sticky event-dropped flag
//  Revision    : 1.0  initial release
// ============================================================================
module seg_capture
    import myPkg::*;
#(
    parameter int NUM_SEG    = 6,
    parameter int STABLE_CNT = 4,
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SEG-1:0]         dig_sel,
    input  logic [7:0]                 seg_in,
    input  logic                       evt_ready,
    input  logic                       ovf_clr,
    output logic                       evt_valid,
    output logic [$clog2(NUM_SEG)-1:0] evt_idx,
    output logic [3:0]                 evt_nib,
    output logic                       evt_dp,
    output logic                       evt_err,
    output logic [3:0]                 nib_out [0:NUM_SEG-1],
    output logic [NUM_SEG-1:0]         digit_vld,
    output logic                       ovf
);

    localparam int IDX_W = $clog2(NUM_SEG);
    localparam int CNT_W = $clog2(STABLE_CNT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic [NUM_SEG-1:0] r_sel;
    logic [7:0]         r_seg;
    logic [NUM_SEG-1:0] r_prev_sel;
    logic [7:0]         r_prev_seg;
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_nib [0:NUM_SEG-1];
    logic [NUM_SEG-1:0] r_dp;
    logic [NUM_SEG-1:0] r_vld;
    logic               r_ovf;

    logic               w_valid;
    logic               w_same;
    logic [CNT_W-1:0]   w_run;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_commit;
    logic [IDX_W-1:0]   w_idx;
    logic [4:0]         w_dec;
    logic               w_ok;
    logic               w_dp;
    logic               w_wr;
    logic               w_pop;
    logic               w_full;
    logic               w_drop;
    seg_evt_t           w_evt;
    seg_evt_t           w_head;

    // Input sample plus the one before it, for run detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= '0;
            r_seg      <= '0;
            r_prev_sel <= '0;
            r_prev_seg <= '0;
        end else begin
            r_sel      <= dig_sel;
            r_seg      <= seg_in;
            r_prev_sel <= r_sel;
            r_prev_seg <= r_seg;
        end
    end

    assign w_valid = (r_sel != '0) && ((r_sel & (r_sel - NUM_SEG'(1))) == '0);
    assign w_same  = (r_sel == r_prev_sel) && (r_seg == r_prev_seg);
    assign w_run   = (r_state == S_TRACK && w_same) ? r_cnt + CNT_W'(1) : CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        if (!w_valid) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else if (!(r_state == S_LOCKED && w_same)) begin
            // New or continuing run; reaching the threshold is the commit.
            w_cnt_nxt = w_run;
            if (w_run == CNT_W'(STABLE_CNT)) begin
                w_state_nxt = S_LOCKED;
                w_commit    = 1'b1;
            end else begin
                w_state_nxt = S_TRACK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_SEG; i++)
            if (r_sel[i])
                w_idx = IDX_W'(i);
    end

    assign w_dec = seg_dec(r_seg[6:0]);
    assign w_ok  = w_dec[4];
    assign w_dp  = r_seg[SEG_DP_BIT];

    // Only report commits that carry news: errors, first sighting, or change.
    assign w_wr = w_commit && (!w_ok || !r_vld[w_idx] ||
                               r_nib[w_idx] != w_dec[3:0] || r_dp[w_idx] != w_dp);

    always_comb begin
        w_evt     = '0;
        w_evt.idx = SEG_IDX_W'(w_idx);
        w_evt.nib = w_dec[3:0];
        w_evt.dp  = w_dp;
        w_evt.err = !w_ok;
    end

    // Undecodable patterns leave the stored digit untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SEG; i++)
                r_nib[i] <= '0;
            r_dp  <= '0;
            r_vld <= '0;
        end else if (w_commit && w_ok) begin
            r_nib[w_idx] <= w_dec[3:0];
            r_dp[w_idx]  <= w_dp;
            r_vld[w_idx] <= 1'b1;
        end
    end

    assign w_pop  = evt_valid && evt_ready;
    assign w_drop = w_wr && w_full && !w_pop;

    // Overflow takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (ovf_clr)
            r_ovf <= 1'b0;
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr),
        .wr_data (w_evt),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .valid   (evt_valid),
        .full    (w_full)
    );

    assign evt_idx   = IDX_W'(w_head.idx);
    assign evt_nib   = w_head.nib;
    assign evt_dp    = w_head.dp;
    assign evt_err   = w_head.err;
    assign nib_out   = r_nib;
    assign digit_vld = r_vld;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
